// File: rtl/pipeline_register_stage_if.sv
// Valid/ready handshake bundle for pipeline_register_stage: upstream (in_*) and downstream (out_*) sides.
// The stage binds to the slave modport; the producer/consumer environment uses master.
interface pipeline_register_stage_if #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;

   modport slave (
      input  in_valid, in_data, in_ctrl, out_ready,
      output in_ready, out_valid, out_data, out_ctrl
   );

   modport master (
      output in_valid, in_data, in_ctrl, out_ready,
      input  in_ready, out_valid, out_data, out_ctrl
   );
endinterface

// File: rtl/pipeline_register_stage.sv
// Two-entry pipeline register (head + skid) with stall/flush control and bubble-safe control output.
// in_ready depends only on registered state, stall and flush, so there is no in_valid -> in_ready path.
module pipeline_register_stage #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       stall,
   pipeline_register_stage_if.slave   bus,
   output logic [1:0]                 occupancy
);

   // Encoding equals the number of held entries, so occupancy is the state itself.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [DATA_W-1:0] main_data;
   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;
   logic              in_ready;
   logic              out_valid;
   logic              push;
   logic              pop;
   logic              load_main_in;
   logic              load_main_skid;
   logic              load_skid;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      in_ready       = (state != TWO) & ~stall & ~flush;
      out_valid      = (state != EMPTY) & ~stall;
      push           = bus.in_valid & in_ready;
      pop            = out_valid & bus.out_ready;
      state_next     = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;

      case (state)
         EMPTY: begin
            if (push) begin
               state_next   = ONE;
               load_main_in = 1'b1;
            end
         end
         ONE: begin
            if (push && pop) begin
               load_main_in = 1'b1;
            end else if (push) begin
               state_next = TWO;
               load_skid  = 1'b1;
            end else if (pop) begin
               state_next = EMPTY;
            end
         end
         TWO: begin
            if (pop) begin
               state_next     = ONE;
               load_main_skid = 1'b1;
            end
         end
         default: state_next = EMPTY;
      endcase

      // Flush squashes everything, including a pop presented in the same cycle.
      if (flush) begin
         state_next     = EMPTY;
         load_main_in   = 1'b0;
         load_main_skid = 1'b0;
         load_skid      = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: payload registers are reset too, because the reset outputs (out_data=0) are observable.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         main_data <= '0;
         main_ctrl <= '0;
         skid_data <= '0;
         skid_ctrl <= '0;
      end else if (flush) begin
         main_ctrl <= '0;
         skid_ctrl <= '0;
      end else begin
         if (load_main_in) begin
            main_data <= bus.in_data;
            main_ctrl <= bus.in_ctrl;
         end else if (load_main_skid) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
         end
         if (load_skid) begin
            skid_data <= bus.in_data;
            skid_ctrl <= bus.in_ctrl;
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = main_data;
   assign bus.out_ctrl  = out_valid ? main_ctrl : '0;
   assign occupancy     = state;

endmodule

// File: tb/tb_pipeline_register_stage.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference,
// with a driver that predicts handshakes and a monitor that scores every presented head entry.
module tb_pipeline_register_stage;

   typedef struct {
      logic [31:0] data;
      logic [7:0]  ctrl;
   } entry_t;

   logic        clock;
   logic        reset;
   logic        flush;
   logic        stall;
   logic [1:0]  occupancy;
   logic        w_flush;
   logic        w_stall;
   logic [1:0]  w_occupancy;

   int errors = 0;
   int checks = 0;

   entry_t sb[$];

   pipeline_register_stage_if #(.DATA_W(32), .CTRL_W(8)) bus ();
   pipeline_register_stage_if #(.DATA_W(64), .CTRL_W(3)) wbus ();

   pipeline_register_stage #(.DATA_W(32), .CTRL_W(8)) dut (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .stall     (stall),
      .bus       (bus),
      .occupancy (occupancy)
   );

   pipeline_register_stage #(.DATA_W(64), .CTRL_W(3)) dut_wide (
      .clock     (clock),
      .reset     (reset),
      .flush     (w_flush),
      .stall     (w_stall),
      .bus       (wbus),
      .occupancy (w_occupancy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus: drive after negedge, check control outputs against the model,
   // then (after the monitor has scored the head) record any accepted entry or squash.
   task automatic cycle(input logic v, input logic [31:0] d, input logic [7:0] c,
                        input logic s, input logic f, input logic r);
      logic exp_ready;
      @(negedge clock);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.in_ctrl   = c;
      bus.out_ready = r;
      stall         = s;
      flush         = f;
      #1;
      exp_ready = (sb.size() < 2) && !s && !f;
      check("in_ready",  64'(bus.in_ready),  64'(exp_ready));
      check("occupancy", 64'(occupancy),     64'(sb.size()));
      check("out_valid", 64'(bus.out_valid), 64'((sb.size() > 0) && !s));
      #2;
      if (f) sb.delete();
      else if (exp_ready && v) sb.push_back('{data: d, ctrl: c});
   endtask

   task automatic idle(input logic r);
      cycle(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, r);
   endtask

   // Monitor: whenever the stage presents a head, it must be the oldest outstanding entry.
   initial begin
      entry_t head;
      forever begin
         @(negedge clock);
         #2;
         if (bus.out_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_empty: head %0h presented with no entry expected", bus.out_data);
            end else begin
               head = sb[0];
               check("out_data", 64'(bus.out_data), 64'(head.data));
               check("out_ctrl", 64'(bus.out_ctrl), 64'(head.ctrl));
               if (bus.out_ready && !flush) void'(sb.pop_front());
            end
         end else begin
            check("bubble_ctrl", 64'(bus.out_ctrl), 64'h0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b1;
      flush         = 1'b0;
      stall         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_ctrl   = '0;
      bus.out_ready = 1'b0;
      w_flush        = 1'b0;
      w_stall        = 1'b0;
      wbus.in_valid  = 1'b0;
      wbus.in_data   = '0;
      wbus.in_ctrl   = '0;
      wbus.out_ready = 1'b0;
      #1;
      check("rst_occupancy", 64'(occupancy),     64'h0);
      check("rst_out_valid", 64'(bus.out_valid), 64'h0);
      check("rst_out_data",  64'(bus.out_data),  64'h0);
      check("rst_out_ctrl",  64'(bus.out_ctrl),  64'h0);
      check("rst_in_ready",  64'(bus.in_ready),  64'h1);
      @(negedge clock);
      reset = 1'b0;

      // Stream: one entry per cycle, occupancy stays at 1.
      for (int i = 1; i <= 4; i++)
         cycle(1'b1, 32'hA0 + 32'(i), 8'(i), 1'b0, 1'b0, 1'b1);
      idle(1'b1);
      idle(1'b1);

      // Backpressure: fill both registers, then drain in order.
      cycle(1'b1, 32'h11, 8'h01, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h22, 8'h02, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'hDEAD, 8'h03, 1'b0, 1'b0, 1'b0);
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);

      // Stall: held entry hidden as a bubble for 3 cycles, then presented unchanged.
      cycle(1'b1, 32'h5A, 8'h81, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 32'hBAD, 8'hFF, 1'b1, 1'b0, 1'b1);
      idle(1'b1);
      idle(1'b1);

      // Flush with a simultaneous push: everything squashed, 0x33 never appears.
      cycle(1'b1, 32'h66, 8'h06, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h77, 8'h07, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h33, 8'h33, 1'b0, 1'b1, 1'b1);
      idle(1'b1);
      idle(1'b1);

      // Asynchronous reset between edges with two entries held.
      cycle(1'b1, 32'h44, 8'h04, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h55, 8'h05, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      #3;
      reset = 1'b1;
      #1;
      check("arst_occupancy", 64'(occupancy),    64'h0);
      check("arst_out_data",  64'(bus.out_data), 64'h0);
      check("arst_out_ctrl",  64'(bus.out_ctrl), 64'h0);
      check("arst_in_ready",  64'(bus.in_ready), 64'h1);
      sb.delete();
      @(negedge clock);
      reset = 1'b0;
      cycle(1'b1, 32'h99, 8'h09, 1'b0, 1'b0, 1'b1);
      idle(1'b1);

      // Random traffic against the queue model.
      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 3) != 0, $urandom, 8'($urandom),
               $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
               $urandom_range(0, 2) != 0);
      for (int i = 0; i < 3; i++) idle(1'b1);
      check("drained", 64'(sb.size()), 64'h0);

      // Wide configuration: 64-bit payload and 3-bit control pass intact.
      @(negedge clock);
      wbus.in_valid  = 1'b1;
      wbus.in_data   = 64'hFFFF_FFFF_FFFF_FFFF;
      wbus.in_ctrl   = 3'b101;
      wbus.out_ready = 1'b1;
      @(negedge clock);
      wbus.in_valid = 1'b0;
      #1;
      check("wide_out_valid", 64'(wbus.out_valid), 64'h1);
      check("wide_out_data",  wbus.out_data,       64'hFFFF_FFFF_FFFF_FFFF);
      check("wide_out_ctrl",  64'(wbus.out_ctrl),  64'h5);
      check("wide_occupancy", 64'(w_occupancy),    64'h1);
      @(negedge clock);
      #1;
      check("wide_drained",   64'(wbus.out_valid), 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
